// File: rtl/duck_hunt_pkg.sv
// Shared definitions for the sprite renderer: sequencer states, screen defaults
// and the palette constants used by the VGA plot path.
package duck_hunt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StErase,
    StDraw,
    StDone
  } state_e;

  localparam int unsigned DEF_SCREEN_W  = 160;
  localparam int unsigned DEF_SCREEN_H  = 120;

  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] BLACK = 3'b000;

  localparam int unsigned DEF_BG_COLOUR = int'(BLACK);

  // Counter width that stays legal when the range collapses to a single value.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_pixel_scan.sv
// Row-major scan over the sprite bitmap: produces the candidate pixel position,
// its bitmap bit and whether it lands on the visible screen.
module sprite_pixel_scan
  import duck_hunt_pkg::*;
#(
  parameter int unsigned SPR_W    = 8,
  parameter int unsigned SPR_H    = 8,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   advance,
  input  logic                   clear,
  input  logic [X_W-1:0]         pos_x,
  input  logic [Y_W-1:0]         pos_y,
  input  logic [SPR_W*SPR_H-1:0] bitmap,
  output logic                   last,
  output logic                   qualified,
  output logic [X_W-1:0]         pix_x,
  output logic [Y_W-1:0]         pix_y
);

  localparam int unsigned CW  = clog2_min1(SPR_W);
  localparam int unsigned RW  = clog2_min1(SPR_H);
  localparam int unsigned BW  = clog2_min1(SPR_W * SPR_H);
  localparam int unsigned XW1 = X_W + 1;
  localparam int unsigned YW1 = Y_W + 1;

  localparam logic [CW-1:0] LastCol = CW'(SPR_W - 1);
  localparam logic [RW-1:0] LastRow = RW'(SPR_H - 1);
  localparam logic [X_W:0]  XLim    = XW1'(SCREEN_W);
  localparam logic [Y_W:0]  YLim    = YW1'(SCREEN_H);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [BW-1:0] bit_idx;
  logic [X_W:0]  cand_x;
  logic [Y_W:0]  cand_y;
  logic          bm_bit;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (advance) begin
      if (col_q == LastCol) begin
        col_q <= '0;
        row_q <= (row_q == LastRow) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // One extra bit on each axis so a sprite hanging off the right/bottom edge
  // compares as off-screen instead of wrapping back to column/row 0.
  always_comb begin
    last      = (col_q == LastCol) && (row_q == LastRow);
    bit_idx   = BW'(row_q) * BW'(SPR_W) + BW'(col_q);
    bm_bit    = bitmap[bit_idx];
    cand_x    = {1'b0, pos_x} + XW1'(col_q);
    cand_y    = {1'b0, pos_y} + YW1'(row_q);
    qualified = bm_bit && (cand_x < XLim) && (cand_y < YLim);
    pix_x     = cand_x[X_W-1:0];
    pix_y     = cand_y[Y_W-1:0];
  end

endmodule

// File: rtl/sprite_render_sequencer.sv
// Per-frame erase/redraw sequencer: walks every sprite slot, erasing its old
// footprint and drawing it at the new position into a valid/ready pixel stream.
module sprite_render_sequencer
  import duck_hunt_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 7,
  parameter int unsigned SPR_W       = 8,
  parameter int unsigned SPR_H       = 8,
  parameter int unsigned X_W         = 8,
  parameter int unsigned Y_W         = 7,
  parameter int unsigned COLOUR_W    = 3,
  parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H    = DEF_SCREEN_H,
  parameter int unsigned BG_COLOUR   = DEF_BG_COLOUR
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            frame_tick,
  input  logic [NUM_SPRITES*X_W-1:0]      sprite_x,
  input  logic [NUM_SPRITES*Y_W-1:0]      sprite_y,
  input  logic [NUM_SPRITES-1:0]          sprite_en,
  input  logic [NUM_SPRITES*COLOUR_W-1:0] sprite_colour,
  input  logic [SPR_W*SPR_H-1:0]          sprite_bitmap,
  output logic [X_W-1:0]                  plot_x,
  output logic [Y_W-1:0]                  plot_y,
  output logic [COLOUR_W-1:0]             plot_colour,
  output logic                            plot_valid,
  input  logic                            plot_ready,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            overrun
);

  localparam int unsigned IW = clog2_min1(NUM_SPRITES);
  localparam logic [IW-1:0]       LastIdx  = IW'(NUM_SPRITES - 1);
  localparam logic [COLOUR_W-1:0] BgColour = COLOUR_W'(BG_COLOUR);

  state_e                          state_q;
  logic [IW-1:0]                   idx_q;
  logic                            busy_q;
  logic                            done_q;
  logic [NUM_SPRITES*X_W-1:0]      snap_x_q;
  logic [NUM_SPRITES*Y_W-1:0]      snap_y_q;
  logic [NUM_SPRITES-1:0]          snap_en_q;
  logic [NUM_SPRITES*COLOUR_W-1:0] snap_col_q;
  logic [SPR_W*SPR_H-1:0]          snap_bm_q;
  logic [NUM_SPRITES*X_W-1:0]      old_x_q;
  logic [NUM_SPRITES*Y_W-1:0]      old_y_q;
  logic [NUM_SPRITES-1:0]          drawn_q;

  logic                scanning;
  logic                erasing;
  logic                step;
  logic                phase_end;
  logic                last_slot;
  logic                scan_last;
  logic                scan_qual;
  logic                scan_clear;
  logic [X_W-1:0]      cur_x;
  logic [Y_W-1:0]      cur_y;
  logic [COLOUR_W-1:0] cur_colour;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;

  always_comb begin
    erasing    = (state_q == StErase);
    scanning   = erasing || (state_q == StDraw);
    scan_clear = (state_q == StIdle);
    last_slot  = (idx_q == LastIdx);
    cur_x      = erasing ? old_x_q[idx_q*X_W +: X_W] : snap_x_q[idx_q*X_W +: X_W];
    cur_y      = erasing ? old_y_q[idx_q*Y_W +: Y_W] : snap_y_q[idx_q*Y_W +: Y_W];
    cur_colour = erasing ? BgColour : snap_col_q[idx_q*COLOUR_W +: COLOUR_W];
    // Unqualified candidates never wait for the sink.
    step       = scanning && (!scan_qual || plot_ready);
    phase_end  = step && scan_last;
  end

  sprite_pixel_scan #(
    .SPR_W    (SPR_W),
    .SPR_H    (SPR_H),
    .X_W      (X_W),
    .Y_W      (Y_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_scan (
    .clock     (clock),
    .resetn    (resetn),
    .advance   (step),
    .clear     (scan_clear),
    .pos_x     (cur_x),
    .pos_y     (cur_y),
    .bitmap    (snap_bm_q),
    .last      (scan_last),
    .qualified (scan_qual),
    .pix_x     (pix_x),
    .pix_y     (pix_y)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_en_q  <= '0;
      snap_col_q <= '0;
      snap_bm_q  <= '0;
      old_x_q    <= '0;
      old_y_q    <= '0;
      drawn_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_tick) begin
            snap_x_q   <= sprite_x;
            snap_y_q   <= sprite_y;
            snap_en_q  <= sprite_en;
            snap_col_q <= sprite_colour;
            snap_bm_q  <= sprite_bitmap;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= StSelect;
          end
        end
        StSelect: begin
          if (drawn_q[idx_q]) begin
            state_q <= StErase;
          end else if (snap_en_q[idx_q]) begin
            state_q <= StDraw;
          end else if (last_slot) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        StErase: begin
          if (phase_end) begin
            if (snap_en_q[idx_q]) begin
              state_q <= StDraw;
            end else begin
              drawn_q[idx_q] <= 1'b0;
              if (last_slot) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StSelect;
                idx_q   <= idx_q + IW'(1);
              end
            end
          end
        end
        StDraw: begin
          if (phase_end) begin
            old_x_q[idx_q*X_W +: X_W] <= snap_x_q[idx_q*X_W +: X_W];
            old_y_q[idx_q*Y_W +: Y_W] <= snap_y_q[idx_q*Y_W +: Y_W];
            drawn_q[idx_q]            <= 1'b1;
            if (last_slot) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StSelect;
              idx_q   <= idx_q + IW'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    plot_valid  = scanning && scan_qual;
    plot_x      = plot_valid ? pix_x : '0;
    plot_y      = plot_valid ? pix_y : '0;
    plot_colour = plot_valid ? cur_colour : '0;
    busy        = busy_q;
    frame_done  = done_q;
    overrun     = frame_tick && (state_q != StIdle);
  end

endmodule
